// File: rtl/csync_separator.sv
// ---------------------------------------------------------------------------
// csync_separator
//
// Purpose: separates an active-low composite sync into a glitch-filtered
// hsync and a width-detected vsync. It also measures the line period and
// flags loss of sync.
//
// Ports:
//   PCLK_i          sample clock; all logic runs on its rising edge
//   reset_i         synchronous, active-high reset
//   CSYNC_i         composite sync, active-low, already polarity-normalized
//   glitch_thold_i  glitch filter length G; a level must persist G+1 cycles
//   sep_thold_i     vsync separation threshold S in cycles; 0 disables vsync
//   HS_o            filtered hsync, active-low
//   VS_o            separated vsync, active-low
//   sogref_update_o one-cycle pulse per accepted csync falling edge
//   hs_period_o     cycles between the last two accepted falling edges
//   sync_lost_o     high when no transition has been seen for 2^CNT_W-1 cycles
// ---------------------------------------------------------------------------
module csync_separator #(
    parameter int CNT_W = 12
) (
    input  logic             PCLK_i,
    input  logic             reset_i,
    input  logic             CSYNC_i,
    input  logic [3:0]       glitch_thold_i,
    input  logic [CNT_W-1:0] sep_thold_i,
    output logic             HS_o,
    output logic             VS_o,
    output logic             sogref_update_o,
    output logic [CNT_W-1:0] hs_period_o,
    output logic             sync_lost_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        VS_IDLE,
        VS_ACTIVE
    } vs_state_t;

    logic             csync_r;
    logic             csf;
    logic             csf_nxt;
    logic [4:0]       mis_cnt;
    logic [4:0]       mis_cnt_nxt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             fall_now;
    logic             rise_now;
    vs_state_t        vs_state;
    vs_state_t        vs_state_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Glitch filter: csf follows csync_r only after G+1 consecutive
    // disagreeing cycles. The >= keeps the filter sane if G is lowered
    // while a mismatch run is already longer than the new G.
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        csf_nxt     = csf;
        mis_cnt_nxt = '0;
        if (csync_r != csf) begin
            if (mis_cnt >= {1'b0, glitch_thold_i}) begin
                csf_nxt = csync_r;
            end else begin
                mis_cnt_nxt = mis_cnt + 5'd1;
            end
        end
    end

    assign fall_now = csf & ~csf_nxt;
    assign rise_now = ~csf & csf_nxt;

    // Vsync detection. A falling edge that lands exactly when high_cnt
    // reaches S wins: the half-line continues and vsync stays active.
    always_comb begin
        vs_state_nxt = vs_state;
        if (sep_thold_i == '0) begin
            vs_state_nxt = VS_IDLE;
        end else begin
            case (vs_state)
                VS_IDLE:
                    if (!csf && low_cnt == sep_thold_i) vs_state_nxt = VS_ACTIVE;
                VS_ACTIVE:
                    if (high_cnt == sep_thold_i && !fall_now) vs_state_nxt = VS_IDLE;
                default:
                    vs_state_nxt = VS_IDLE;
            endcase
        end
    end

    assign VS_o = (vs_state != VS_ACTIVE);

    // NOTE: state registers use non-blocking assignments so that every
    // right-hand side reads the value from before this clock edge.
    always_ff @(posedge PCLK_i) begin
        if (reset_i) begin
            csync_r         <= 1'b1;
            csf             <= 1'b1;
            mis_cnt         <= '0;
            low_cnt         <= '0;
            high_cnt        <= '0;
            per_cnt         <= '0;
            HS_o            <= 1'b1;
            sogref_update_o <= 1'b0;
            hs_period_o     <= '0;
            sync_lost_o     <= 1'b1;
            vs_state        <= VS_IDLE;
        end else begin
            csync_r  <= CSYNC_i;
            csf      <= csf_nxt;
            mis_cnt  <= mis_cnt_nxt;
            vs_state <= vs_state_nxt;

            // HS_o lags csf by one cycle. The pulse is therefore the csf fall
            // seen one cycle late, which lines it up with the HS_o edge.
            HS_o            <= csf;
            sogref_update_o <= HS_o & ~csf;

            // Level-duration counters: 1 in the first cycle of a new level.
            if (fall_now)      low_cnt <= CNT_ONE;
            else if (rise_now) low_cnt <= '0;
            else if (!csf)     low_cnt <= sat_inc(low_cnt);

            if (rise_now)      high_cnt <= CNT_ONE;
            else if (fall_now) high_cnt <= '0;
            else if (csf)      high_cnt <= sat_inc(high_cnt);

            // Period counter: holds the cycles since the last fall when the
            // next fall arrives. After a loss the stale count is replaced
            // by the saturated value.
            if (fall_now) begin
                per_cnt     <= CNT_ONE;
                hs_period_o <= sync_lost_o ? CNT_MAX : per_cnt;
            end else begin
                per_cnt <= sat_inc(per_cnt);
            end

            if (fall_now || rise_now) begin
                sync_lost_o <= 1'b0;
            end else if (low_cnt == CNT_MAX || high_cnt == CNT_MAX) begin
                sync_lost_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csync_separator.sv
// ---------------------------------------------------------------------------
// tb_csync_separator
//
// Directed bench for csync_separator. Each driven line pushes its expected
// hs_period_o value into a queue. A monitor pops one entry per
// sogref_update_o pulse, so missing, extra or wrong-period lines all show.
// ---------------------------------------------------------------------------
module tb_csync_separator;

    localparam int CNT_W = 12;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             PCLK_i = 1'b0;
    logic             reset_i;
    logic             CSYNC_i;
    logic [3:0]       glitch_thold_i;
    logic [CNT_W-1:0] sep_thold_i;
    logic             HS_o;
    logic             VS_o;
    logic             sogref_update_o;
    logic [CNT_W-1:0] hs_period_o;
    logic             sync_lost_o;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    // Results of the most recent drive_line call (k = cycle index in line).
    int r_hs_fall;
    int r_hs_low;
    int r_vs_fall;
    int r_vs_rise;

    csync_separator #(.CNT_W(CNT_W)) dut (
        .PCLK_i          (PCLK_i),
        .reset_i         (reset_i),
        .CSYNC_i         (CSYNC_i),
        .glitch_thold_i  (glitch_thold_i),
        .sep_thold_i     (sep_thold_i),
        .HS_o            (HS_o),
        .VS_o            (VS_o),
        .sogref_update_o (sogref_update_o),
        .hs_period_o     (hs_period_o),
        .sync_lost_o     (sync_lost_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK_i);
        #1;
    endtask

    // One line: CSYNC_i low for low_len cycles, total per cycles. Outputs
    // are sampled 1 time unit after every rising edge.
    task automatic drive_line(input int low_len, input int per);
        logic prev_vs;
        r_hs_fall = 0;
        r_hs_low  = 0;
        r_vs_fall = 0;
        r_vs_rise = 0;
        prev_vs   = VS_o;
        CSYNC_i   = 1'b0;
        for (int k = 1; k <= per; k++) begin
            tick();
            if (k == low_len) CSYNC_i = 1'b1;
            if (HS_o === 1'b0) begin
                r_hs_low++;
                if (r_hs_fall == 0) r_hs_fall = k;
            end
            if (prev_vs === 1'b1 && VS_o === 1'b0 && r_vs_fall == 0) r_vs_fall = k;
            if (prev_vs === 1'b0 && VS_o === 1'b1 && r_vs_rise == 0) r_vs_rise = k;
            prev_vs = VS_o;
        end
    endtask

    // Scoreboard: each sogref pulse consumes one expected period.
    always @(negedge PCLK_i) begin
        if (sogref_update_o === 1'b1) begin
            if (exp_q.size() == 0) check("sog_unexpected", 32'(sogref_update_o), 32'd0);
            else                   check("hs_period", 32'(hs_period_o), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        reset_i        = 1'b1;
        CSYNC_i        = 1'b1;
        glitch_thold_i = 4'd3;
        sep_thold_i    = CNT_W'(200);

        // Reset holds every output while CSYNC_i toggles.
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            CSYNC_i = ~CSYNC_i;
            @(negedge PCLK_i);
            check("rst_hs",     32'(HS_o),            32'd1);
            check("rst_vs",     32'(VS_o),            32'd1);
            check("rst_sog",    32'(sogref_update_o), 32'd0);
            check("rst_period", 32'(hs_period_o),     32'd0);
            check("rst_lost",   32'(sync_lost_o),     32'd1);
        end
        tick();
        reset_i = 1'b0;
        CSYNC_i = 1'b1;

        // Glitch rejection with G=3.
        drive_line(3, 30);
        check("g3_hs_fall", 32'(r_hs_fall),   32'd0);
        check("g3_hs_low",  32'(r_hs_low),    32'd0);
        check("g3_lost",    32'(sync_lost_o), 32'd1);
        check("g3_period",  32'(hs_period_o), 32'd0);
        exp_q.push_back(MAXV);
        drive_line(4, 30);
        check("g4_hs_fall", 32'(r_hs_fall),   32'd6);
        check("g4_hs_low",  32'(r_hs_low),    32'd4);
        check("g4_lost",    32'(sync_lost_o), 32'd0);
        check("g4_vs",      32'(VS_o),        32'd1);

        // Idle long enough to lose sync, then steady lines with G=2.
        glitch_thold_i = 4'd2;
        repeat (5000) tick();
        check("idle_lost", 32'(sync_lost_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(i == 0 ? MAXV : 858);
            drive_line(63, 858);
            check("line_hs_low", 32'(r_hs_low),  32'd63);
            check("line_vs",     32'(r_vs_fall), 32'd0);
        end
        check("line_lost", 32'(sync_lost_o), 32'd0);

        // Sync loss: period holds, next fall loads the saturated value.
        repeat (5000) tick();
        check("loss_flag", 32'(sync_lost_o), 32'd1);
        check("loss_hold", 32'(hs_period_o), 32'd858);
        exp_q.push_back(MAXV);
        drive_line(63, 858);
        check("loss_clear", 32'(sync_lost_o), 32'd0);
        exp_q.push_back(858);
        drive_line(63, 858);

        // Vsync with S=200: six broad pulses, the last followed by a long high.
        for (int b = 0; b < 6; b++) begin
            exp_q.push_back(b == 0 ? 858 : 429);
            drive_line(366, b == 5 ? 858 : 429);
            check("vs_fall", 32'(r_vs_fall), b == 0 ? 32'd204 : 32'd0);
            check("vs_rise", 32'(r_vs_rise), b == 5 ? 32'd570 : 32'd0);
        end
        exp_q.push_back(858);
        drive_line(63, 858);
        check("post_vs_fall", 32'(r_vs_fall), 32'd0);
        check("post_vs",      32'(VS_o),      32'd1);

        // S=63: the 63-cycle high between broad pulses hits high_cnt==S exactly
        // on the next fall, so vsync must not drop out.
        sep_thold_i = CNT_W'(63);
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back(b == 0 ? 858 : 429);
            drive_line(366, 429);
            check("tie_vs_fall", 32'(r_vs_fall), b == 0 ? 32'd67 : 32'd0);
            check("tie_vs_rise", 32'(r_vs_rise), 32'd0);
        end

        // S=0 forces vsync inactive within one cycle.
        sep_thold_i = '0;
        tick();
        check("sep0_vs", 32'(VS_o), 32'd1);
        sep_thold_i = CNT_W'(63);
        exp_q.push_back(430);
        drive_line(366, 429);
        check("s63_vs_fall", 32'(r_vs_fall), 32'd67);
        check("s63_vs_low",  32'(VS_o),      32'd0);

        // Reset in the middle of vsync.
        reset_i = 1'b1;
        tick();
        check("mid_rst_vs",     32'(VS_o),        32'd1);
        check("mid_rst_hs",     32'(HS_o),        32'd1);
        check("mid_rst_period", 32'(hs_period_o), 32'd0);
        check("mid_rst_lost",   32'(sync_lost_o), 32'd1);
        tick();
        reset_i     = 1'b0;
        sep_thold_i = CNT_W'(200);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i == 0 ? MAXV : 858);
            drive_line(63, 858);
            check("rec_vs", 32'(r_vs_fall), 32'd0);
        end
        check("rec_period", 32'(hs_period_o), 32'd858);

        repeat (10) tick();
        check("sog_missing", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
